// File: rtl/stats_arb_pkg.sv
// Shared types and constants for the stats read-port arbiter.
// FSM state encoding, requester count and stats address alignment.
package stats_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int NREQ             = 2;
    localparam int STATS_ALIGN_BITS = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-input picker with last-grant register.
// Round-robin by default; STATS_RD_ARB_FIXED_PRIO_EN selects strict priority to requester 0.
module rr_arb2
    import stats_arb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            take,
    output logic [NREQ-1:0] gnt,
    output logic            gnt_idx
);

    logic last_gnt;

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_gnt <= 1'b1;
        else if (take)
            last_gnt <= gnt_idx;
    end

    always_comb begin
        gnt_idx = 1'b0;
`ifdef STATS_RD_ARB_FIXED_PRIO_EN
        gnt_idx = req[1] && !req[0];
`else
        if (req == 2'b11)
            gnt_idx = !last_gnt;
        else
            gnt_idx = req[1];
`endif
        gnt = '0;
        if (req != '0)
            gnt = gnt_idx ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/stats_rd_arb.sv
// Arbitrates the 64-bit stats read port between host register reads and the stats pusher.
// Build option: STATS_RD_ARB_FIXED_PRIO_EN (strict priority instead of round-robin).
module stats_rd_arb
    import stats_arb_pkg::*;
#(
    parameter int ADDR_BITS = 16,
    parameter int RD_LAT    = 1
) (
    input  logic                 pcie_clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [ADDR_BITS-1:0] req_addr0,
    input  logic [ADDR_BITS-1:0] req_addr1,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [63:0]          resp_data,
    output logic                 rd_mem_valid,
    output logic                 rd_en_lo,
    output logic                 rd_en_hi,
    output logic [ADDR_BITS-1:0] rd_addr_lo,
    output logic [ADDR_BITS-1:0] rd_addr_hi,
    input  logic [31:0]          rd_data_lo,
    input  logic [31:0]          rd_data_hi,
    output logic [31:0]          gnt_cnt0,
    output logic [31:0]          gnt_cnt1
);

    localparam logic [ADDR_BITS-1:0] ALIGN_MASK = ADDR_BITS'((1 << STATS_ALIGN_BITS) - 1);

    state_t               state, state_nxt;
    logic [NREQ-1:0]      gnt;
    logic                 gnt_idx;
    logic                 accept;
    logic                 owner;
    logic [2:0]           wait_cnt;
    logic                 wait_done;
    logic [ADDR_BITS-1:0] sel_addr;
    logic [ADDR_BITS-1:0] addr_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    rr_arb2 u_arb (
        .clk     (pcie_clk),
        .rst     (rst),
        .req     (req_valid),
        .take    (accept),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign accept     = (state == IDLE) && !rst && (req_valid != '0);
    assign req_ready  = accept ? gnt : '0;
    assign sel_addr   = gnt_idx ? req_addr1 : req_addr0;
    // Count 0 is the cycle right after ISSUE, so matching RD_LAT gives the 2+RD_LAT response latency.
    assign wait_done  = (state == WAIT) && (wait_cnt == 3'(RD_LAT));
    assign rd_addr_lo = addr_q;
    assign rd_addr_hi = addr_q;

    always_ff @(posedge pcie_clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        rd_mem_valid = 1'b0;
        rd_en_lo     = 1'b0;
        rd_en_hi     = 1'b0;
        resp_valid   = '0;
        case (state)
            IDLE:  if (accept) state_nxt = ISSUE;
            ISSUE: begin
                rd_mem_valid = 1'b1;
                rd_en_lo     = 1'b1;
                rd_en_hi     = 1'b1;
                state_nxt    = WAIT;
            end
            WAIT:  if (wait_done) state_nxt = RESP;
            RESP: begin
                resp_valid[owner] = 1'b1;
                if (resp_ready[owner])
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pcie_clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            owner     <= 1'b0;
            wait_cnt  <= '0;
            resp_data <= '0;
            gnt_cnt0  <= '0;
            gnt_cnt1  <= '0;
        end else begin
            if (accept) begin
                addr_q <= sel_addr & ~ALIGN_MASK;
                owner  <= gnt_idx;
                if (gnt_idx)
                    gnt_cnt1 <= sat_inc(gnt_cnt1);
                else
                    gnt_cnt0 <= sat_inc(gnt_cnt0);
            end
            if (state == ISSUE)
                wait_cnt <= '0;
            else if (state == WAIT)
                wait_cnt <= wait_cnt + 3'd1;
            if (wait_done)
                resp_data <= {rd_data_hi, rd_data_lo};
        end
    end

endmodule

// File: tb/tb_stats_rd_arb.sv
// Directed bench for stats_rd_arb with a combinational stats read model.
module tb_stats_rd_arb;
    logic        pcie_clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_addr0, req_addr1;
    logic [1:0]  req_ready, resp_valid, resp_ready;
    logic [63:0] resp_data;
    logic        rd_mem_valid, rd_en_lo, rd_en_hi;
    logic [15:0] rd_addr_lo, rd_addr_hi;
    logic [31:0] rd_data_lo, rd_data_hi;
    logic [31:0] gnt_cnt0, gnt_cnt1;

    int tests = 0;
    int fails = 0;

    always #5 pcie_clk = ~pcie_clk;

    stats_rd_arb #(.ADDR_BITS(16), .RD_LAT(1)) dut (
        .pcie_clk     (pcie_clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr0    (req_addr0),
        .req_addr1    (req_addr1),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .rd_mem_valid (rd_mem_valid),
        .rd_en_lo     (rd_en_lo),
        .rd_en_hi     (rd_en_hi),
        .rd_addr_lo   (rd_addr_lo),
        .rd_addr_hi   (rd_addr_hi),
        .rd_data_lo   (rd_data_lo),
        .rd_data_hi   (rd_data_hi),
        .gnt_cnt0     (gnt_cnt0),
        .gnt_cnt1     (gnt_cnt1)
    );

    // Stats model: one fixed entry, everything else encodes its own address.
    always_comb begin
        rd_data_lo = {16'hA000, rd_addr_lo};
        rd_data_hi = {16'hB000, rd_addr_hi};
        if (rd_addr_lo == 16'h0408) begin
            rd_data_lo = 32'h11223344;
            rd_data_hi = 32'h55667788;
        end
    end

    task automatic wait_resp(output bit to);
        int n = 0;
        while (resp_valid == 2'b00 && n < 30) begin
            @(negedge pcie_clk);
            n++;
        end
        to = (n >= 30);
    endtask

    // Call at a negedge with req_valid already driven; returns at a negedge after the handshake.
    task automatic do_txn(output int w, output bit to);
        int n = 0;
        w  = -1;
        to = 1'b0;
        #1;
        while (req_ready == 2'b00 && n < 30) begin
            @(negedge pcie_clk);
            #1;
            n++;
        end
        if (n >= 30) begin
            to = 1'b1;
            return;
        end
        w = req_ready[1] ? 1 : 0;
        @(negedge pcie_clk);
        wait_resp(to);
        if (to) return;
        resp_ready = resp_valid;
        @(negedge pcie_clk);
        resp_ready = 2'b00;
    endtask

    task automatic pulse_reset();
        @(negedge pcie_clk);
        rst = 1'b1;
        @(negedge pcie_clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge pcie_clk);
        #1;
        tests++;
        if (req_ready !== 2'b00 || resp_valid !== 2'b00) begin
            fails++;
            $display("FAIL reset_hs: req_ready=%b resp_valid=%b required 00/00", req_ready, resp_valid);
        end
        tests++;
        if (resp_data !== 64'd0) begin
            fails++;
            $display("FAIL reset_data: got %h required 0", resp_data);
        end
        tests++;
        if ({rd_mem_valid, rd_en_lo, rd_en_hi} !== 3'b000 || rd_addr_lo !== 16'd0 || rd_addr_hi !== 16'd0) begin
            fails++;
            $display("FAIL reset_rd: en=%b%b%b addr=%h/%h required 0", rd_mem_valid, rd_en_lo, rd_en_hi, rd_addr_lo, rd_addr_hi);
        end
        tests++;
        if (gnt_cnt0 !== 32'd0 || gnt_cnt1 !== 32'd0) begin
            fails++;
            $display("FAIL reset_cnt: got %h/%h required 0/0", gnt_cnt0, gnt_cnt1);
        end
        @(negedge pcie_clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        @(negedge pcie_clk);
        req_addr0 = 16'h0408;
        req_valid = 2'b01;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++;
            $display("FAIL single_ready: got %b required 01", req_ready);
        end
        @(negedge pcie_clk);
        req_valid = 2'b00;
        tests++;
        if ({rd_mem_valid, rd_en_lo, rd_en_hi} !== 3'b111 || rd_addr_lo !== 16'h0408 || rd_addr_hi !== 16'h0408) begin
            fails++;
            $display("FAIL single_issue: en=%b%b%b addr=%h/%h required 111 0408", rd_mem_valid, rd_en_lo, rd_en_hi, rd_addr_lo, rd_addr_hi);
        end
        @(negedge pcie_clk);
        tests++;
        if (rd_mem_valid !== 1'b0 || resp_valid !== 2'b00) begin
            fails++;
            $display("FAIL single_wait1: rd_mem_valid=%b resp_valid=%b required 0/00", rd_mem_valid, resp_valid);
        end
        @(negedge pcie_clk);
        tests++;
        if (resp_valid !== 2'b00) begin
            fails++;
            $display("FAIL single_wait2: resp_valid=%b required 00", resp_valid);
        end
        @(negedge pcie_clk);
        tests++;
        if (resp_valid !== 2'b01 || resp_data !== 64'h5566778811223344) begin
            fails++;
            $display("FAIL single_resp: valid=%b data=%h required 01 5566778811223344", resp_valid, resp_data);
        end
        tests++;
        if (gnt_cnt0 !== 32'd1 || gnt_cnt1 !== 32'd0) begin
            fails++;
            $display("FAIL single_cnt: got %0d/%0d required 1/0", gnt_cnt0, gnt_cnt1);
        end
        resp_ready = 2'b01;
        @(negedge pcie_clk);
        resp_ready = 2'b00;
        tests++;
        if (resp_valid !== 2'b00) begin
            fails++;
            $display("FAIL single_done: resp_valid=%b required 00", resp_valid);
        end
    endtask

    task automatic test_unaligned();
        bit to;
        req_addr1 = 16'h040D;
        req_valid = 2'b10;
        #1;
        tests++;
        if (req_ready !== 2'b10) begin
            fails++;
            $display("FAIL unal_ready: got %b required 10", req_ready);
        end
        @(negedge pcie_clk);
        req_valid = 2'b00;
        tests++;
        if (rd_mem_valid !== 1'b1 || rd_addr_lo !== 16'h0408 || rd_addr_hi !== 16'h0408) begin
            fails++;
            $display("FAIL unal_addr: valid=%b addr=%h/%h required 1 0408", rd_mem_valid, rd_addr_lo, rd_addr_hi);
        end
        wait_resp(to);
        tests++;
        if (to || resp_valid !== 2'b10 || resp_data !== 64'h5566778811223344) begin
            fails++;
            $display("FAIL unal_resp: timeout=%0d valid=%b data=%h required 10 5566778811223344", to, resp_valid, resp_data);
        end
        resp_ready = 2'b10;
        @(negedge pcie_clk);
        resp_ready = 2'b00;
    endtask

    task automatic test_backpressure();
        bit to;
        req_addr0 = 16'h0010;
        req_valid = 2'b01;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++;
            $display("FAIL bp_ready0: got %b required 01", req_ready);
        end
        @(negedge pcie_clk);
        req_addr1 = 16'h0020;
        req_valid = 2'b10;
        wait_resp(to);
        tests++;
        if (to) begin
            fails++;
            $display("FAIL bp_timeout: no resp_valid within 30 cycles");
        end
        resp_ready = 2'b10;
        for (int i = 0; i < 10; i++) begin
            #1;
            tests++;
            if (resp_valid !== 2'b01 || resp_data !== {32'hB0000010, 32'hA0000010} || req_ready !== 2'b00) begin
                fails++;
                $display("FAIL bp_stall%0d: valid=%b data=%h ready=%b required 01 b0000010a0000010 00", i, resp_valid, resp_data, req_ready);
            end
            @(negedge pcie_clk);
        end
        resp_ready = 2'b01;
        #1;
        tests++;
        if (req_ready !== 2'b00) begin
            fails++;
            $display("FAIL bp_hs_cycle: req_ready=%b required 00", req_ready);
        end
        @(negedge pcie_clk);
        resp_ready = 2'b00;
        #1;
        tests++;
        if (req_ready !== 2'b10 || resp_valid !== 2'b00) begin
            fails++;
            $display("FAIL bp_next_ready: req_ready=%b resp_valid=%b required 10/00", req_ready, resp_valid);
        end
        @(negedge pcie_clk);
        req_valid = 2'b00;
        tests++;
        if (rd_mem_valid !== 1'b1 || rd_addr_lo !== 16'h0020) begin
            fails++;
            $display("FAIL bp_issue1: valid=%b addr=%h required 1 0020", rd_mem_valid, rd_addr_lo);
        end
        wait_resp(to);
        tests++;
        if (to || resp_valid !== 2'b10 || resp_data !== {32'hB0000020, 32'hA0000020}) begin
            fails++;
            $display("FAIL bp_resp1: timeout=%0d valid=%b data=%h required 10 b0000020a0000020", to, resp_valid, resp_data);
        end
        resp_ready = 2'b10;
        @(negedge pcie_clk);
        resp_ready = 2'b00;
    endtask

    task automatic test_round_robin();
        int w;
        bit to;
        int exp_w[4];
`ifdef STATS_RD_ARB_FIXED_PRIO_EN
        exp_w = '{0, 0, 0, 0};
`else
        exp_w = '{0, 1, 0, 1};
`endif
        pulse_reset();
        req_addr0 = 16'h0100;
        req_addr1 = 16'h0200;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            do_txn(w, to);
            tests++;
            if (to || w != exp_w[i]) begin
                fails++;
                $display("FAIL rr_order%0d: timeout=%0d granted %0d required %0d", i, to, w, exp_w[i]);
            end
        end
        req_valid = 2'b00;
        tests++;
`ifdef STATS_RD_ARB_FIXED_PRIO_EN
        if (gnt_cnt0 !== 32'd4 || gnt_cnt1 !== 32'd0) begin
            fails++;
            $display("FAIL rr_cnt: got %0d/%0d required 4/0", gnt_cnt0, gnt_cnt1);
        end
`else
        if (gnt_cnt0 !== 32'd2 || gnt_cnt1 !== 32'd2) begin
            fails++;
            $display("FAIL rr_cnt: got %0d/%0d required 2/2", gnt_cnt0, gnt_cnt1);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int w;
        bit to;
        int seen;
        req_addr0 = 16'h0030;
        req_valid = 2'b01;
        @(negedge pcie_clk);
        req_valid = 2'b00;
        @(negedge pcie_clk);
        rst = 1'b1;
        #1;
        tests++;
        if ({rd_mem_valid, rd_en_lo, rd_en_hi} !== 3'b000 || rd_addr_lo !== 16'd0 || resp_data !== 64'd0 ||
            resp_valid !== 2'b00 || gnt_cnt0 !== 32'd0 || gnt_cnt1 !== 32'd0) begin
            fails++;
            $display("FAIL rstmid_async: en=%b addr=%h data=%h valid=%b cnt=%0d/%0d required all 0",
                     rd_mem_valid, rd_addr_lo, resp_data, resp_valid, gnt_cnt0, gnt_cnt1);
        end
        @(negedge pcie_clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge pcie_clk);
            if (resp_valid !== 2'b00 || rd_mem_valid !== 1'b0) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL rstmid_quiet: %0d active cycles after reset required 0", seen);
        end
        req_addr0 = 16'h0048;
        req_addr1 = 16'h0050;
        req_valid = 2'b11;
        do_txn(w, to);
        req_valid = 2'b00;
        tests++;
        if (to || w != 0 || gnt_cnt0 !== 32'd1) begin
            fails++;
            $display("FAIL rstmid_tie: timeout=%0d granted %0d cnt0=%0d required 0 1", to, w, gnt_cnt0);
        end
    endtask

    task automatic test_saturation();
        int w;
        bit to;
        force dut.gnt_cnt0 = 32'hFFFF_FFFE;
        #1;
        release dut.gnt_cnt0;
        @(negedge pcie_clk);
        req_addr0 = 16'h0060;
        req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            do_txn(w, to);
            tests++;
            if (to || gnt_cnt0 !== 32'hFFFF_FFFF) begin
                fails++;
                $display("FAIL sat_cnt%0d: timeout=%0d cnt0=%h required ffffffff", i, to, gnt_cnt0);
            end
        end
        req_valid = 2'b00;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 2'b00;
        req_addr0  = 16'd0;
        req_addr1  = 16'd0;
        resp_ready = 2'b00;
        test_reset();
        test_single();
        test_unaligned();
        test_backpressure();
        test_round_robin();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
